seq_gen_moore: RTL

- Serial pattern generator built as a Moore FSM. It is the transmit-side counterpart of the team's serial sequence detectors.
- On a start request it captures a PAT_W-bit pattern and shifts it out MSB-first on a single-bit stream. The pattern is repeated a programmable number of times, with programmable idle gaps between repetitions.
- Used to drive detector inputs and serial test links from a simple start/busy/done control interface.

---
 rtl/seq_gen_moore_pkg.sv | 14 +
 rtl/seq_gen_shreg.sv | 28 ++
 rtl/seq_gen_moore.sv | 126 ++++++++++++
 3 files changed

// File: rtl/seq_gen_moore_pkg.sv
// Shared types for the serial pattern generator.
// State encodings and the default demo pattern.
package seq_gen_moore_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [3:0] PAT_DEF = 4'b1011;

endpackage

// File: rtl/seq_gen_shreg.sv
// Loadable left-shift register; load wins over shift.
// The MSB is the bit currently on the wire.
module seq_gen_shreg #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] d,
  output logic             msb
);

  logic [PAT_W-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[PAT_W-2:0], 1'b0};
    end
  end

  assign msb = q[PAT_W-1];

endmodule

// File: rtl/seq_gen_moore.sv
// Moore serial pattern generator: sends a captured pattern
// MSB-first, repeated i_rpt+1 times with i_gap idle cycles between.
module seq_gen_moore
  import seq_gen_moore_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [PAT_W-1:0] i_pat,
  input  logic [CNT_W-1:0] i_rpt,
  input  logic [GAP_W-1:0] i_gap,
  output logic             o_seq,
  output logic             o_bit_vld,
  output logic             o_busy,
  output logic             o_done
);

  localparam int BW = $clog2(PAT_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rpt_q, rpt_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             load, shift, msb;
  logic [PAT_W-1:0] load_val;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      rpt_q     <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      bit_q     <= '0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      rpt_q     <= rpt_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      bit_q     <= bit_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    rpt_d     = rpt_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    bit_d     = bit_q;
    load      = 1'b0;
    shift     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          load      = 1'b1;
          pat_d     = i_pat;
          rpt_d     = i_rpt;
          gap_len_d = i_gap;
          bit_d     = BIT_LAST;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift = 1'b1;
        bit_d = bit_q - 1'b1;
        if (bit_q == '0) begin
          if (rpt_q == '0) begin
            state_d = S_DONE;
          end else if (gap_len_q == '0) begin
            // back-to-back reload, no bubble
            load  = 1'b1;
            rpt_d = rpt_q - 1'b1;
            bit_d = BIT_LAST;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = gap_len_q - 1'b1;
            rpt_d     = rpt_q - 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          load    = 1'b1;
          bit_d   = BIT_LAST;
          state_d = S_SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign load_val = (state_q == S_IDLE) ? i_pat : pat_q;

  seq_gen_shreg #(
    .PAT_W(PAT_W)
  ) u_shreg (
    .clk  (i_clk),
    .rst  (i_rst),
    .load (load),
    .shift(shift),
    .d    (load_val),
    .msb  (msb)
  );

  assign o_seq     = (state_q == S_SHIFT) & msb;
  assign o_bit_vld = (state_q == S_SHIFT);
  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = (state_q == S_DONE);

endmodule
